// File: rtl/fft_sample_loader.sv
// fft_sample_loader: writer-side front end for top_fft.
// Accepts complex samples over valid/ready and writes them into the FFT input
// sample RAM (port 1). After N_SAMPLES words it pulses fft_start, then blocks
// new input until fft_finish.
// Short frames (in_last early) are zero-filled to N_SAMPLES and flag err_len.
// Optional macro FFT_LOADER_BITREV_EN: when defined, write addresses are the
// bit-reversed sample index (the input order of the in-place DIT core). When
// undefined, addresses follow the natural order.
//
// state | meaning
// ------+-----------------------------------------------------------
// LOAD  | accepting samples; in_ready high
// ZFILL | short frame: writing zeros to the remaining indices
// START | last write has landed; issue the one-cycle fft_start
// WAIT  | FFT running; input blocked until fft_finish
module fft_sample_loader #(
    parameter int N_SAMPLES  = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       in_re,
    input  logic [DATA_WIDTH-1:0]       in_im,
    input  logic                        in_last,
    output logic                        mem_we,
    output logic [$clog2(N_SAMPLES)-1:0] mem_addr,
    output logic [2*DATA_WIDTH-1:0]     mem_wdata,
    output logic                        fft_start,
    input  logic                        fft_finish,
    output logic                        busy,
    output logic                        err_len
);
    localparam int AW = $clog2(N_SAMPLES);
    localparam logic [AW-1:0] LAST_IDX = AW'(N_SAMPLES - 1);

    typedef enum logic [1:0] {LOAD, ZFILL, START, WAIT} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] count;
    logic          handshake;

    // Maps the sample index within a frame to its RAM address.
    function automatic logic [AW-1:0] addr_map(input logic [AW-1:0] idx);
        logic [AW-1:0] r;
        r = idx;
`ifdef FFT_LOADER_BITREV_EN
        for (int b = 0; b < AW; b++) begin
            r[b] = idx[AW-1-b];
        end
`endif
        return r;
    endfunction

    // Ready is held low while rst is asserted so nothing is accepted in reset.
    assign in_ready  = (state == LOAD) && !rst;
    assign handshake = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the final index ends the frame whatever in_last says.
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: begin
                if (handshake) begin
                    if (count == LAST_IDX) begin
                        state_nxt = START;
                    end else if (in_last) begin
                        state_nxt = ZFILL;
                    end
                end
            end
            ZFILL: begin
                if (count == LAST_IDX) begin
                    state_nxt = START;
                end
            end
            START:   state_nxt = WAIT;
            WAIT: begin
                if (fft_finish) begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Registered write port, sample counter, start pulse and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            fft_start <= 1'b0;
            busy      <= 1'b0;
            err_len   <= 1'b0;
            count     <= '0;
        end else begin
            mem_we    <= 1'b0;
            fft_start <= 1'b0;
            case (state)
                LOAD: begin
                    if (handshake) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_map(count);
                        mem_wdata <= {in_re, in_im};
                        count     <= count + 1'b1;
                        busy      <= 1'b1;
                        // Length error: last flag early, or missing on the final index.
                        if ((count == LAST_IDX) ^ in_last) begin
                            err_len <= 1'b1;
                        end
                    end
                end
                ZFILL: begin
                    mem_we    <= 1'b1;
                    mem_addr  <= addr_map(count);
                    mem_wdata <= '0;
                    count     <= count + 1'b1;
                end
                START: begin
                    fft_start <= 1'b1;
                    count     <= '0;
                end
                WAIT: begin
                    if (fft_finish) begin
                        busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_sample_loader.sv
// Self-checking bench for fft_sample_loader: random frames against a queue
// scoreboard of expected RAM writes, start timing and sticky length error.
module tb_fft_sample_loader;
    localparam int N  = 8;
    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          fft_finish = 1'b0;
    logic [DW-1:0] in_re = '0;
    logic [DW-1:0] in_im = '0;
    logic          in_ready, mem_we, fft_start, busy, err_len;
    logic [AW-1:0] mem_addr;
    logic [2*DW-1:0] mem_wdata;

    fft_sample_loader #(.N_SAMPLES(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .fft_start(fft_start), .fft_finish(fft_finish),
        .busy(busy), .err_len(err_len)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    int              exp_addr_q[$];
    logic [2*DW-1:0] exp_data_q[$];
    int start_count = 0;
    int start_cyc   = 0;
    bit exp_err     = 1'b0;
    int idx         = 0;
    int hs_edge     = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Address for sample index k: bit-reversed digits, or the index itself.
    function automatic int exp_addr(input int k);
        int r = 0;
`ifdef FFT_LOADER_BITREV_EN
        for (int b = 0; b < AW; b++) r = r * 2 + ((k >> b) & 1);
`else
        r = k;
`endif
        return r;
    endfunction

    // Write/start monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            if (exp_addr_q.size() == 0) begin
                check("spurious_write", 1, 0);
            end else begin
                check("mem_addr", mem_addr, exp_addr_q.pop_front());
                check("mem_wdata", mem_wdata, exp_data_q.pop_front());
            end
        end
        if (fft_start) begin
            start_count++;
            start_cyc = cyc;
            check("writes_landed_before_start", exp_addr_q.size(), 0);
        end
    end

    task automatic send_sample(input logic [DW-1:0] re, input logic [DW-1:0] im,
                               input bit last, input int gap);
        bit hs = 1'b0;
        int t  = 0;
        in_valid = 1'b0;
        repeat (gap) begin
            fft_finish = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        fft_finish = 1'b0;
        in_valid = 1'b1; in_re = re; in_im = im; in_last = last;
        while (!hs && t < 50) begin
            @(negedge clk); hs = in_ready;
            @(posedge clk); #1; t++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        if (!hs) begin
            check("handshake_timeout", 0, 1);
            return;
        end
        hs_edge = cyc;
        exp_addr_q.push_back(exp_addr(idx));
        exp_data_q.push_back({re, im});
        idx++;
        check("busy_after_hs", busy, 1);
    endtask

    task automatic send_frame(input int len, input bit last_flag, input int gap_mode, input bit pattern);
        int sc0 = start_count;
        int t = 0;
        int g;
        logic [DW-1:0] re, im;
        idx = 0;
        check("busy_idle", busy, 0);
        check("in_ready_idle", in_ready, 1);
        for (int i = 0; i < len; i++) begin
            if (pattern) begin re = DW'(i); im = DW'(-i); end
            else begin re = DW'($urandom); im = DW'($urandom); end
            if (gap_mode == 0) g = 0;
            else if (gap_mode == 1) g = (i == 0) ? 0 : 1;
            else g = $urandom_range(0, 2);
            send_sample(re, im, (i == len - 1) ? last_flag : 1'b0, g);
        end
        for (int k = len; k < N; k++) begin
            exp_addr_q.push_back(exp_addr(k));
            exp_data_q.push_back('0);
        end
        if (len != N || !last_flag) exp_err = 1'b1;
        while (start_count == sc0 && t < 40) begin @(posedge clk); #1; t++; end
        repeat (3) begin @(posedge clk); #1; end
        check("start_pulses", start_count - sc0, 1);
        // Write cycle follows the last handshake edge, start the cycle after
        // the last (possibly zero-fill) write.
        check("start_latency", start_cyc - hs_edge, 1 + N - len);
        check("err_len", err_len, exp_err);
        check("busy_wait", busy, 1);
        in_valid = 1'b1; in_re = DW'($urandom); in_im = DW'($urandom);
        repeat (3) begin @(negedge clk); check("in_ready_wait", in_ready, 0); end
        @(posedge clk); #1;
        fft_finish = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        fft_finish = 1'b0;
        check("busy_after_finish", busy, 0);
        check("ready_after_finish", in_ready, 1);
        check("no_pending_writes", exp_addr_q.size(), 0);
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_fft_start", fft_start, 0);
        check("rst_busy", busy, 0);
        check("rst_err_len", err_len, 0);
    endtask

    initial begin
        int sc0;
        int len;
        bit lf;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        send_frame(8, 1'b1, 0, 1'b1);   // back-to-back ramp
        send_frame(8, 1'b1, 1, 1'b1);   // valid toggling
        send_frame(5, 1'b1, 0, 1'b1);   // short frame, zero fill
        send_frame(8, 1'b0, 2, 1'b0);   // missing in_last

        // Reset in the middle of a frame.
        idx = 0;
        for (int i = 0; i < 3; i++) send_sample(DW'($urandom), DW'($urandom), 1'b0, 0);
        @(negedge clk); #1;
        rst = 1'b1; #1;
        check_reset_values();
        exp_err = 1'b0;
        check("writes_before_reset", exp_addr_q.size(), 0);
        exp_addr_q.delete(); exp_data_q.delete();
        sc0 = start_count;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("no_start_after_reset", start_count - sc0, 0);

        send_frame(8, 1'b1, 0, 1'b0);
        repeat (6) begin
            len = $urandom_range(1, N);
            lf  = (len == N) ? 1'($urandom_range(0, 1)) : 1'b1;
            send_frame(len, lf, 2, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
